// File: rtl/load_reg_bank.sv
// load_reg_bank: CHANNELS load registers of WIDTH bits sharing one write path.
// One addressed channel per cycle can be loaded, shifted left/right or rotated left.
// Each channel has a dirty flag. With LOAD_REG_BANK_SNAPSHOT_EN defined, a shadow
// copy of every channel is captured on snap for coherent readback.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   ld         operation strobe (one op per cycle)
//   op         00 LOAD, 01 SHL, 10 SHR, 11 ROL
//   wr_sel     target channel of ld; out-of-range selects are ignored
//   data_in    LOAD value
//   ser_in     serial bit shifted in by SHL/SHR
//   rd_sel     channel shown on data and snap_data (out of range reads 0)
//   data       live value of channel rd_sel
//   ser_out    registered bit last shifted or rotated out
//   dirty      per-channel modified-since-snapshot flags
//   snap       snapshot strobe (ignored when snapshot support is not built)
//   snap_data  shadow value of channel rd_sel (0 when snapshot support is not built)
//
// Build option: LOAD_REG_BANK_SNAPSHOT_EN enables the shadow registers.
module load_reg_bank #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ld,
  input  logic [1:0]          op,
  input  logic [SEL_W-1:0]    wr_sel,
  input  logic [WIDTH-1:0]    data_in,
  input  logic                ser_in,
  input  logic [SEL_W-1:0]    rd_sel,
  output logic [WIDTH-1:0]    data,
  output logic                ser_out,
  output logic [CHANNELS-1:0] dirty,
  input  logic                snap,
  output logic [WIDTH-1:0]    snap_data
);

  typedef enum logic [1:0] {
    OpLoad = 2'b00,
    OpShl  = 2'b01,
    OpShr  = 2'b10,
    OpRol  = 2'b11
  } op_e;

  logic [WIDTH-1:0]    reg_q [CHANNELS];
  logic [WIDTH-1:0]    reg_d [CHANNELS];
  logic                ser_out_q, ser_out_d;
  logic [CHANNELS-1:0] dirty_q, dirty_d;

  // Only selects matching a real channel index take effect, so out-of-range
  // writes fall through with no state change.
  always_comb begin
    reg_d     = reg_q;
    ser_out_d = ser_out_q;
    dirty_d   = dirty_q;
`ifdef LOAD_REG_BANK_SNAPSHOT_EN
    if (snap) begin
      dirty_d = '0;
    end
`endif
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (ld && (wr_sel == SEL_W'(i))) begin
        // Set after the snap clear so a same-edge write stays dirty.
        dirty_d[i] = 1'b1;
        unique case (op_e'(op))
          OpLoad: reg_d[i] = data_in;
          OpShl: begin
            reg_d[i]  = {reg_q[i][WIDTH-2:0], ser_in};
            ser_out_d = reg_q[i][WIDTH-1];
          end
          OpShr: begin
            reg_d[i]  = {ser_in, reg_q[i][WIDTH-1:1]};
            ser_out_d = reg_q[i][0];
          end
          OpRol: begin
            reg_d[i]  = {reg_q[i][WIDTH-2:0], reg_q[i][WIDTH-1]};
            ser_out_d = reg_q[i][WIDTH-1];
          end
          default: reg_d[i] = reg_q[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_q     <= '{default: '0};
      ser_out_q <= 1'b0;
      dirty_q   <= '0;
    end else begin
      reg_q     <= reg_d;
      ser_out_q <= ser_out_d;
      dirty_q   <= dirty_d;
    end
  end

  always_comb begin
    data = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        data = reg_q[i];
      end
    end
  end

  assign ser_out = ser_out_q;
  assign dirty   = dirty_q;

`ifdef LOAD_REG_BANK_SNAPSHOT_EN
  logic [WIDTH-1:0] shadow_q [CHANNELS];
  logic [WIDTH-1:0] shadow_d [CHANNELS];

  // Shadow takes the pre-operation value when snap and ld share an edge.
  always_comb begin
    shadow_d = shadow_q;
    if (snap) begin
      shadow_d = reg_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q <= '{default: '0};
    end else begin
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    snap_data = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        snap_data = shadow_q[i];
      end
    end
  end
`else
  logic unused_snap;
  assign unused_snap = snap;
  assign snap_data   = '0;
`endif

endmodule

// File: tb/tb_load_reg_bank.sv
// Bench for load_reg_bank: a 4-channel and a 3-channel instance share all inputs
// and are compared every cycle against an arithmetic reference model, plus
// directed scenarios with literal expectations.
module tb_load_reg_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       ld;
  logic [1:0] op;
  logic [1:0] wr_sel;
  logic [7:0] data_in;
  logic       ser_in;
  logic [1:0] rd_sel;
  logic       snap;

  logic [7:0] data4, snap4, data3, snap3;
  logic       ser4, ser3;
  logic [3:0] dirty4;
  logic [2:0] dirty3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_reg_bank #(.WIDTH(8), .CHANNELS(4)) dut4 (
    .clk(clk), .reset(reset), .ld(ld), .op(op), .wr_sel(wr_sel), .data_in(data_in),
    .ser_in(ser_in), .rd_sel(rd_sel), .data(data4), .ser_out(ser4), .dirty(dirty4),
    .snap(snap), .snap_data(snap4)
  );

  load_reg_bank #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .clk(clk), .reset(reset), .ld(ld), .op(op), .wr_sel(wr_sel), .data_in(data_in),
    .ser_in(ser_in), .rd_sel(rd_sel), .data(data3), .ser_out(ser3), .dirty(dirty3),
    .snap(snap), .snap_data(snap3)
  );

  // Reference model: index 0 is the 4-channel bank, index 1 the 3-channel bank.
  int m_reg   [2][4];
  int m_shd   [2][4];
  int m_dirty [2];
  int m_ser   [2];
  int nch     [2] = '{4, 3};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 4; c++) begin
        m_reg[k][c] = 0;
        m_shd[k][c] = 0;
      end
      m_dirty[k] = 0;
      m_ser[k]   = 0;
    end
  endtask

  // Applies the inputs sampled on the current edge.
  task automatic model_step();
    int s;
    int r;
    s = int'(wr_sel);
    for (int k = 0; k < 2; k++) begin
`ifdef LOAD_REG_BANK_SNAPSHOT_EN
      if (snap) begin
        for (int c = 0; c < 4; c++) m_shd[k][c] = m_reg[k][c];
        m_dirty[k] = 0;
      end
`endif
      if (ld && s < nch[k]) begin
        r = m_reg[k][s];
        case (int'(op))
          0: r = int'(data_in);
          1: begin
            m_ser[k] = (r >> 7) & 1;
            r = ((r << 1) | int'(ser_in)) & 255;
          end
          2: begin
            m_ser[k] = r & 1;
            r = (r >> 1) | (int'(ser_in) << 7);
          end
          default: begin
            m_ser[k] = (r >> 7) & 1;
            r = ((r << 1) | (r >> 7)) & 255;
          end
        endcase
        m_reg[k][s] = r;
        m_dirty[k] = m_dirty[k] | (1 << s);
      end
    end
  endtask

  function automatic int exp_data(input int k);
    int s;
    s = int'(rd_sel);
    return (s < nch[k]) ? m_reg[k][s] : 0;
  endfunction

  function automatic int exp_snap(input int k);
    int s;
    s = int'(rd_sel);
`ifdef LOAD_REG_BANK_SNAPSHOT_EN
    return (s < nch[k]) ? m_shd[k][s] : 0;
`else
    return 0;
`endif
  endfunction

  task automatic check_all();
    check("data4",  32'(data4),  exp_data(0));
    check("snap4",  32'(snap4),  exp_snap(0));
    check("dirty4", 32'(dirty4), m_dirty[0]);
    check("ser4",   32'(ser4),   m_ser[0]);
    check("data3",  32'(data3),  exp_data(1));
    check("snap3",  32'(snap3),  exp_snap(1));
    check("dirty3", 32'(dirty3), m_dirty[1]);
    check("ser3",   32'(ser3),   m_ser[1]);
  endtask

  task automatic step(input logic l, input logic [1:0] o, input logic [1:0] ws,
                      input logic [7:0] di, input logic si, input logic sn);
    ld = l; op = o; wr_sel = ws; data_in = di; ser_in = si; snap = sn;
    @(posedge clk);
    model_step();
    #1;
    ld = 1'b0; snap = 1'b0;
  endtask

  task automatic read_chk(input logic [1:0] sel);
    rd_sel = sel;
    #1;
    check_all();
  endtask

  // Mid-cycle reset: outputs must clear before the next edge, and an op
  // presented across an edge under reset must be discarded.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    check("rst_dirty4", 32'(dirty4), 0);
    ld = 1'b1; op = 2'b00; wr_sel = 2'd0; data_in = 8'hFF; snap = 1'b1;
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
    ld = 1'b0; snap = 1'b0;
    #1;
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      step(($urandom_range(0, 3) != 0), 2'($urandom), 2'($urandom), 8'($urandom),
           1'($urandom), ($urandom_range(0, 7) == 0));
      read_chk(2'($urandom));
    end
  endtask

  initial begin
    reset = 1'b1; ld = 1'b0; op = 2'b00; wr_sel = '0; data_in = '0; ser_in = 1'b0;
    rd_sel = '0; snap = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;

    random_run(200);
    // Bank holds random nonzero state here.
    #1;
    do_reset();

    // LOAD/read isolation.
    step(1'b1, 2'b00, 2'd2, 8'hA5, 1'b0, 1'b0);
    step(1'b1, 2'b00, 2'd0, 8'h3C, 1'b0, 1'b0);
    read_chk(2'd2); check("iso_ch2", 32'(data4), 32'hA5);
    read_chk(2'd0); check("iso_ch0", 32'(data4), 32'h3C);
    read_chk(2'd1); check("iso_ch1", 32'(data4), 32'h00);
    read_chk(2'd3); check("iso_ch3", 32'(data4), 32'h00);
    check("iso_dirty", 32'(dirty4), 32'b0101);

    // Shift/rotate on ch1 = 0x81.
    step(1'b1, 2'b00, 2'd1, 8'h81, 1'b0, 1'b0);
    step(1'b1, 2'b01, 2'd1, 8'h00, 1'b0, 1'b0);
    read_chk(2'd1); check("shl_val", 32'(data4), 32'h02); check("shl_ser", 32'(ser4), 1);
    step(1'b1, 2'b10, 2'd1, 8'h00, 1'b1, 1'b0);
    read_chk(2'd1); check("shr_val", 32'(data4), 32'h81); check("shr_ser", 32'(ser4), 0);
    step(1'b1, 2'b11, 2'd1, 8'h00, 1'b0, 1'b0);
    read_chk(2'd1); check("rol_val", 32'(data4), 32'h03); check("rol_ser", 32'(ser4), 1);

    // Simultaneous snap and ld.
    do_reset();
    step(1'b1, 2'b00, 2'd0, 8'h11, 1'b0, 1'b0);
    step(1'b1, 2'b00, 2'd0, 8'h22, 1'b0, 1'b1);
    read_chk(2'd0);
    check("sim_data", 32'(data4), 32'h22);
`ifdef LOAD_REG_BANK_SNAPSHOT_EN
    check("sim_snap", 32'(snap4), 32'h11);
`else
    check("sim_snap", 32'(snap4), 32'h00);
`endif
    check("sim_dirty", 32'(dirty4), 32'b0001);

    // Out-of-range select on the 3-channel bank.
    do_reset();
    step(1'b1, 2'b00, 2'd3, 8'hFF, 1'b0, 1'b0);
    read_chk(2'd3); check("oor_data3", 32'(data3), 0); check("oor_snap3", 32'(snap3), 0);
    check("oor_dirty3", 32'(dirty3), 0);
    check("oor_ch3_4", 32'(data4), 32'hFF);
    for (int c = 0; c < 3; c++) begin
      read_chk(2'(c)); check("oor_hold3", 32'(data3), 0);
    end

    // LOAD ch3 then snap.
    do_reset();
    step(1'b1, 2'b00, 2'd3, 8'h5A, 1'b0, 1'b0);
    step(1'b0, 2'b00, 2'd0, 8'h00, 1'b0, 1'b1);
    read_chk(2'd3);
`ifdef LOAD_REG_BANK_SNAPSHOT_EN
    check("snp_data", 32'(snap4), 32'h5A);
    check("snp_dirty", 32'(dirty4), 32'b0000);
`else
    check("snp_data", 32'(snap4), 32'h00);
    check("snp_dirty", 32'(dirty4), 32'b1000);
`endif

    random_run(300);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_reg_bank.md
# load_reg_bank

Parametrised bank of CHANNELS load registers, each WIDTH bits, with per-cycle load, shift and rotate operations on one addressed channel. It also keeps a per-channel dirty flag and an optional snapshot shadow copy for coherent readback. It replaces single-channel load registers wherever several related registers are written through one shared data path, e.g. datapath operand or control-register files.

## Interface

- WIDTH, 8, bits per channel; legal range 2 or more.
- CHANNELS, 4, number of channels; legal range 2 or more, need not be a power of two.
- SEL_W, $clog2(CHANNELS), derived select width; never overridden.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- ld  in  1  operation strobe; one operation per cycle while high.
- op  in  2  operation: 00 LOAD, 01 SHL, 10 SHR, 11 ROL.
- wr_sel  in  SEL_W  channel targeted by ld.
- data_in  in  WIDTH  LOAD value.
- ser_in  in  1  serial bit shifted in by SHL/SHR.
- rd_sel  in  SEL_W  channel shown on data and snap_data.
- data  out  WIDTH  live value of channel rd_sel.
- ser_out  out  1  registered bit last shifted or rotated out.
- dirty  out  CHANNELS  bit i set when channel i was modified since the last snapshot.
- snap  in  1  snapshot strobe.
- snap_data  out  WIDTH  shadow value of channel rd_sel.

## Operation

- Reset (async assert, sync-to-clk deassert by the system): all channels, all shadows, dirty and ser_out go to 0 immediately; any in-flight operation is discarded.
- On each rising edge with ld=1 and wr_sel < CHANNELS, channel r = reg[wr_sel] is updated:
  - LOAD: r <= data_in; ser_out unchanged.
  - SHL: r <= {r[WIDTH-2:0], ser_in}; ser_out <= r[WIDTH-1].
  - SHR: r <= {ser_in, r[WIDTH-1:1]}; ser_out <= r[0].
  - ROL: r <= {r[WIDTH-2:0], r[WIDTH-1]}; ser_out <= r[WIDTH-1].
- ld=1 with wr_sel >= CHANNELS: no channel, dirty bit or ser_out changes.
- Other channels hold when not addressed. ld=0 means every channel holds.
- Dirty: any accepted ld sets dirty[wr_sel], including a LOAD of an identical value. An accepted snap clears all dirty bits.
- Snapshot: snap=1 copies every channel into its shadow on that edge.
- snap and ld in the same cycle:
  - The shadow captures the pre-operation value.
  - dirty[wr_sel] ends set (set wins over clear); all other dirty bits clear.
- Reads:
  - data and snap_data are combinational muxes of rd_sel.
  - rd_sel >= CHANNELS drives 0 on both.
- Arithmetic: no carries; shifts move exactly one bit per accepted ld; repeated ops need no idle cycles.

## Timing

- Write latency 1: an op sampled at edge N is visible on data after edge N (same cycle that rd_sel addresses it). No bypass of data_in to data.
- Back-to-back ld on the same channel is applied cumulatively, one op per edge.
- ser_out updates on the edge of the shift or rotate and holds otherwise.
- Snapshot latency 1: snap_data reflects the captured values after the snap edge and holds until the next snap or reset.
- reset asserted mid-sequence: outputs read 0 within the same cycle (async); the first op after deassertion operates on 0.

## Configuration

- LOAD_REG_BANK_SNAPSHOT_EN defined:
  - Shadow registers, snap input and snap_data output are present.
  - dirty clears on snap as above.
- LOAD_REG_BANK_SNAPSHOT_EN undefined:
  - The snap port is still present but ignored, and no shadow registers are built.
  - snap_data is tied to 0.
  - dirty bits, once set, stay set until reset.
  - All other behaviour is identical.

## Test plan

- Reset: drive the bank to nonzero values, then assert reset mid-cycle. data, snap_data, dirty and ser_out must read 0 before the next edge.
- LOAD/read isolation: WIDTH=8, CHANNELS=4. LOAD 0xA5 to ch2 and 0x3C to ch0. Then rd_sel=2 gives 0xA5, rd_sel=0 gives 0x3C, ch1 and ch3 read 0x00, and dirty=4'b0101.
- Shift/rotate on ch1 = 0x81:
  - SHL with ser_in=0 gives 0x02 and ser_out=1.
  - SHR with ser_in=1 gives 0x81 and ser_out=0.
  - ROL gives 0x03 and ser_out=1.
- Simultaneous snap and ld (macro on): ch0 = 0x11, same-edge LOAD 0x22 to ch0 with snap. Then snap_data(ch0)=0x11, data(ch0)=0x22, dirty=4'b0001.
- Out-of-range select: CHANNELS=3 with ld, wr_sel=3, data_in=0xFF. No channel changes, dirty is unchanged, and rd_sel=3 reads 0 on data and snap_data.
- Macro off: LOAD ch3 then pulse snap. snap_data stays 0 and dirty[3] stays 1.
